wb_regfile: RTL

//   Write-back end of the MEM/WB pipeline register: consumes the WB_* bundle,

---
 rtl/wb_regfile.sv | 117 +++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage of the MEM/WB pipeline register. It takes the WB_* bundle,
//   selects the write data and destination, and commits to a 2**ADDR_W x DATA_W
//   register file whose entry 0 is hardwired to zero. It has two combinational
//   ID-stage read ports with same-cycle write-back bypass, a debug read port
//   that shows committed state only, and a retired-instruction counter.
//
// Ports
//   clk          in   clock; all state updates on posedge
//   reset        in   asynchronous, active-low reset
//   WB_Valid     in   bundle holds a real instruction (0 = bubble)
//   WB_RegWr     in   register write enable
//   WB_RegDst    in   2'b10 forces the link register (all-ones index)
//   WB_MemtoReg  in   write-data select: 00/11 ALU, 01 memory, 10 PC+LINK_OFFSET
//   WB_WrReg     in   destination index
//   WB_inA       in   ALU result
//   WB_inB       in   memory read data
//   WB_PC        in   PC of the write-back instruction
//   ID_rs/ID_rt  in   read port A/B indices
//   ID_busA/B    out  read port A/B data, with bypass of a live write
//   dbg_addr     in   debug read index
//   dbg_data     out  debug read data, committed state only
//   wr_fire      out  a write commits at the next posedge
//   retire_cnt   out  number of valid instructions retired (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int LINK_OFFSET = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WB_Valid,
  input  logic              WB_RegWr,
  input  logic [1:0]        WB_RegDst,
  input  logic [1:0]        WB_MemtoReg,
  input  logic [ADDR_W-1:0] WB_WrReg,
  input  logic [DATA_W-1:0] WB_inA,
  input  logic [DATA_W-1:0] WB_inB,
  input  logic [DATA_W-1:0] WB_PC,
  input  logic [ADDR_W-1:0] ID_rs,
  input  logic [ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0] ID_busA,
  output logic [DATA_W-1:0] ID_busB,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wr_fire,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] wdest;

  // Write-data select; 11 aliases the ALU result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wdata = WB_inA;
    case (WB_MemtoReg)
      2'b01:   wdata = WB_inB;
      2'b10:   wdata = WB_PC + DATA_W'(LINK_OFFSET);
      default: wdata = WB_inA;
    endcase
  end

  // The link register is the highest index (31 for the default ADDR_W).
  assign wdest = (WB_RegDst == 2'b10) ? '1 : WB_WrReg;

  // Writes to $0 are suppressed here, so the array entry 0 is never updated and
  // the bypass never forwards to index 0.
  assign wr_fire = WB_Valid & WB_RegWr & (wdest != '0);

  always_comb begin
    ID_busA = '0;
    if (ID_rs != '0) begin
      ID_busA = (wr_fire && (wdest == ID_rs)) ? wdata : regs[ID_rs];
    end
  end

  always_comb begin
    ID_busB = '0;
    if (ID_rt != '0) begin
      ID_busB = (wr_fire && (wdest == ID_rt)) ? wdata : regs[ID_rt];
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the register array is reset because software-visible state must
      // read zero straight out of reset; this is a flop array, not a RAM macro.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[wdest] <= wdata;
    end
  end

  // Counts every valid instruction, whether or not it writes a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
    end else if (WB_Valid) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule
